// File: rtl/ddc_iq_pkg.sv
// Shared widths, FSM state and I/Q pair payload for the DDC-to-I2S frame buffer.
package ddc_iq_pkg;

  localparam int unsigned DEF_IN_W  = 32;
  localparam int unsigned DEF_OUT_W = 24;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [DEF_OUT_W-1:0] re;
    logic [DEF_OUT_W-1:0] im;
  } iq_pair_t;

endpackage

// File: rtl/iq_round_sat.sv
// Round-half-up and saturate a signed IN_W word to OUT_W bits, registered with a valid.
module iq_round_sat #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 24
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid
);

  localparam int unsigned    SH      = IN_W - OUT_W;
  localparam logic [IN_W:0]  RND     = (IN_W+1)'(1) << (SH - 1);
  localparam logic [OUT_W-1:0] SAT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  logic signed [IN_W:0] sum_c;
  logic signed [IN_W:0] shr_c;
  logic                 fits_c;
  logic [OUT_W-1:0]     sat_c;
  logic [OUT_W-1:0]     data_q;
  logic                 valid_q;

  // One guard bit keeps the rounding add from wrapping at the positive limit.
  assign sum_c  = $signed({in_data[IN_W-1], in_data}) + $signed(RND);
  assign shr_c  = sum_c >>> SH;
  assign fits_c = (shr_c[IN_W:OUT_W-1] == '0) || (shr_c[IN_W:OUT_W-1] == '1);
  assign sat_c  = fits_c ? shr_c[OUT_W-1:0] : (shr_c[IN_W] ? SAT_MIN : SAT_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) data_q <= sat_c;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;

endmodule

// File: rtl/iq_frame_buffer.sv
// Rounds decimator I/Q to OUT_W, queues pairs and presents one pair per LRCK frame.
// Optional IQ_SWAP_EN adds iq_swap for per-frame sideband inversion.
module iq_frame_buffer
  import ddc_iq_pkg::*;
#(
  parameter int unsigned IN_W       = DEF_IN_W,
  parameter int unsigned OUT_W      = DEF_OUT_W,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [IN_W-1:0]       in_real,
  input  logic [IN_W-1:0]       in_imag,
  input  logic                  lrck,
`ifdef IQ_SWAP_EN
  input  logic                  iq_swap,
`endif
  input  logic                  clr_flags,
  output logic [OUT_W-1:0]      rx_real,
  output logic [OUT_W-1:0]      rx_imag,
  output logic                  out_update,
  output logic [DEPTH_LOG2:0]   fifo_level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned   DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned   PW    = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] HALF  = PW'(DEPTH / 2);

  logic [OUT_W-1:0] rs_re, rs_im;
  logic             rs_v_re, rs_v_im, rs_valid_c;

  iq_round_sat #(.IN_W(IN_W), .OUT_W(OUT_W)) u_rs_re (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .in_data(in_real), .out_data(rs_re), .out_valid(rs_v_re)
  );

  iq_round_sat #(.IN_W(IN_W), .OUT_W(OUT_W)) u_rs_im (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .in_data(in_imag), .out_data(rs_im), .out_valid(rs_v_im)
  );

  assign rs_valid_c = rs_v_re & rs_v_im;

  state_e        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  iq_pair_t      rx_q, rx_d, head_c, wr_pair_c;
  logic          upd_q, upd_d, ovf_q, ovf_d, unf_q, unf_d;
  logic          lrck_s1_q, lrck_s2_q, lrck_edge_q;
  logic          pop_req_c, push_c, pop_c, empty_c, full_c;
  iq_pair_t      mem_q [DEPTH];

  // Two-flop synchroniser plus edge register; pop_req is the synchronised rise.
  assign pop_req_c = lrck_s2_q & ~lrck_edge_q;
  assign empty_c   = (wr_ptr_q == rd_ptr_q);
  assign full_c    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign head_c    = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  always_comb begin
    wr_pair_c    = '0;
    wr_pair_c.re = rs_re;
    wr_pair_c.im = rs_im;
  end

  always_comb begin
    state_d = state_q;
    rx_d    = rx_q;
    upd_d   = 1'b0;
    ovf_d   = ovf_q & ~clr_flags;
    unf_d   = unf_q & ~clr_flags;
    pop_c   = 1'b0;
    push_c  = 1'b0;
    case (state_q)
      FILL: begin
        if (pop_req_c) begin
          rx_d  = '0;
          upd_d = 1'b1;
        end
        if (level_q >= HALF) state_d = RUN;
      end
      RUN: begin
        if (pop_req_c) begin
          upd_d = 1'b1;
          if (!empty_c) begin
            pop_c = 1'b1;
            rx_d  = head_c;
`ifdef IQ_SWAP_EN
            if (iq_swap) begin
              rx_d.re = head_c.im;
              rx_d.im = head_c.re;
            end
`endif
          end else begin
            rx_d    = '0;
            unf_d   = 1'b1;
            state_d = FILL;
          end
        end
      end
      default: state_d = FILL;
    endcase
    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    if (rs_valid_c) begin
      if (!full_c || pop_c) push_c = 1'b1;
      else                  ovf_d  = 1'b1;
    end
    wr_ptr_d = wr_ptr_q + PW'(push_c);
    rd_ptr_d = rd_ptr_q + PW'(pop_c);
    level_d  = level_q + PW'(push_c) - PW'(pop_c);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rx_q        <= '0;
      upd_q       <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
      lrck_s1_q   <= 1'b0;
      lrck_s2_q   <= 1'b0;
      lrck_edge_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rx_q        <= rx_d;
      upd_q       <= upd_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
      lrck_s1_q   <= lrck;
      lrck_s2_q   <= lrck_s1_q;
      lrck_edge_q <= lrck_s2_q;
    end
  end

  always_ff @(posedge clock) begin
    if (push_c) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_pair_c;
  end

  assign rx_real    = rx_q.re;
  assign rx_imag    = rx_q.im;
  assign out_update = upd_q;
  assign fifo_level = level_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_iq_frame_buffer.sv
// Directed self-checking bench for iq_frame_buffer (default 32->24, depth 4).
module tb_iq_frame_buffer;

  logic        clock = 1'b0;
  logic        reset, in_valid, lrck, clr_flags;
  logic [31:0] in_real, in_imag;
  logic [23:0] rx_real, rx_imag;
  logic        out_update, overflow, underflow;
  logic [2:0]  fifo_level;
`ifdef IQ_SWAP_EN
  logic        iq_swap;
`endif

  int checks   = 0;
  int failures = 0;

  iq_frame_buffer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .in_real(in_real), .in_imag(in_imag), .lrck(lrck),
`ifdef IQ_SWAP_EN
    .iq_swap(iq_swap),
`endif
    .clr_flags(clr_flags), .rx_real(rx_real), .rx_imag(rx_imag),
    .out_update(out_update), .fifo_level(fifo_level),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Round stage takes one edge, the FIFO write a second; level is current on return.
  task automatic push(input logic [31:0] i, input logic [31:0] q);
    in_valid = 1'b1; in_real = i; in_imag = q;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  // One LRCK frame: rx sampled on the third edge after the rise.
  task automatic lrck_pop(output logic [23:0] re, output logic [23:0] im,
                          output logic upd_early, output logic upd, output logic upd_after);
    lrck = 1'b1;
    tick(); tick();
    upd_early = out_update;
    tick();
    re = rx_real; im = rx_imag; upd = out_update;
    lrck = 1'b0;
    tick();
    upd_after = out_update;
    tick(); tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++; if (rx_real !== 24'h0)   begin failures++; $display("FAIL reset_rx_real: got %h expected %h", rx_real, 24'h0); end
    checks++; if (rx_imag !== 24'h0)   begin failures++; $display("FAIL reset_rx_imag: got %h expected %h", rx_imag, 24'h0); end
    checks++; if (out_update !== 1'b0) begin failures++; $display("FAIL reset_update: got %b expected 0", out_update); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    checks++; if (overflow !== 1'b0)   begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (underflow !== 1'b0)  begin failures++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
  endtask

  task automatic test_round_sat();
    logic [23:0] re, im;
    logic e, u, a;
    push(32'h0000_0180, 32'h7FFF_FFFF);
    push(32'hFFFF_FF7F, 32'h8000_0000);
    checks++; if (fifo_level !== 3'd2) begin failures++; $display("FAIL rs_level: got %0d expected 2", fifo_level); end
    lrck_pop(re, im, e, u, a);
    checks++; if (re !== 24'h000002) begin failures++; $display("FAIL rs_round_up: got %h expected %h", re, 24'h000002); end
    checks++; if (im !== 24'h7FFFFF) begin failures++; $display("FAIL rs_sat_pos: got %h expected %h", im, 24'h7FFFFF); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL rs_update_early: got %b expected 0", e); end
    checks++; if (u !== 1'b1) begin failures++; $display("FAIL rs_update_pulse: got %b expected 1", u); end
    checks++; if (a !== 1'b0) begin failures++; $display("FAIL rs_update_after: got %b expected 0", a); end
    lrck_pop(re, im, e, u, a);
    checks++; if (re !== 24'hFFFFFF) begin failures++; $display("FAIL rs_neg_round: got %h expected %h", re, 24'hFFFFFF); end
    checks++; if (im !== 24'h800000) begin failures++; $display("FAIL rs_neg_min: got %h expected %h", im, 24'h800000); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL rs_no_underflow: got %b expected 0", underflow); end
    lrck_pop(re, im, e, u, a);
    checks++; if ({re, im} !== 48'h0) begin failures++; $display("FAIL uf_rx_zero: got %h expected 0", {re, im}); end
    checks++; if (u !== 1'b1) begin failures++; $display("FAIL uf_update: got %b expected 1", u); end
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL uf_flag: got %b expected 1", underflow); end
  endtask

  task automatic test_fill_run();
    logic [23:0] re, im;
    logic e, u, a;
    push(32'h0000_1000, 32'h0000_2000);
    lrck_pop(re, im, e, u, a);
    checks++; if ({re, im} !== 48'h0) begin failures++; $display("FAIL fill_no_dequeue_rx: got %h expected 0", {re, im}); end
    checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL fill_level: got %0d expected 1", fifo_level); end
    push(32'h0000_3000, 32'h0000_4000);
    lrck_pop(re, im, e, u, a);
    checks++; if ({re, im} !== {24'h10, 24'h20}) begin failures++; $display("FAIL run_pair1: got %h expected %h", {re, im}, {24'h10, 24'h20}); end
    lrck_pop(re, im, e, u, a);
    checks++; if ({re, im} !== {24'h30, 24'h40}) begin failures++; $display("FAIL run_pair2: got %h expected %h", {re, im}, {24'h30, 24'h40}); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL run_level: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_overflow();
    logic [23:0] re, im;
    logic e, u, a;
    for (int k = 1; k <= 5; k++) push(32'(k) << 8, 32'(k + 8) << 8);
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL ovf_level: got %0d expected 4", fifo_level); end
    checks++; if (overflow !== 1'b1)   begin failures++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    for (int k = 1; k <= 4; k++) begin
      lrck_pop(re, im, e, u, a);
      checks++; if ({re, im} !== {24'(k), 24'(k + 8)}) begin failures++; $display("FAIL ovf_pop%0d: got %h expected %h", k, {re, im}, {24'(k), 24'(k + 8)}); end
    end
    lrck_pop(re, im, e, u, a);
    checks++; if ({re, im} !== 48'h0) begin failures++; $display("FAIL ovf_fifth_absent: got %h expected 0", {re, im}); end
  endtask

  task automatic test_flags();
    checks++; if ({overflow, underflow} !== 2'b11) begin failures++; $display("FAIL flags_set: got %b expected 11", {overflow, underflow}); end
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    checks++; if ({overflow, underflow} !== 2'b00) begin failures++; $display("FAIL flags_clear: got %b expected 00", {overflow, underflow}); end
  endtask

  task automatic test_push_pop_full();
    logic [23:0] re, im;
    logic e, u, a;
    for (int k = 0; k < 4; k++) push(32'(8'h11 + k) << 8, 32'(8'h21 + k) << 8);
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL pp_full_level: got %0d expected 4", fifo_level); end
    // Sample reaches the FIFO on the same edge that the synchronised pop lands.
    lrck = 1'b1;
    tick();
    in_valid = 1'b1; in_real = 32'h0000_3000; in_imag = 32'h0000_3100;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if ({rx_real, rx_imag} !== {24'h11, 24'h21}) begin failures++; $display("FAIL pp_head: got %h expected %h", {rx_real, rx_imag}, {24'h11, 24'h21}); end
    checks++; if (out_update !== 1'b1) begin failures++; $display("FAIL pp_update: got %b expected 1", out_update); end
    checks++; if (fifo_level !== 3'd4) begin failures++; $display("FAIL pp_level: got %0d expected 4", fifo_level); end
    checks++; if (overflow !== 1'b0)   begin failures++; $display("FAIL pp_no_overflow: got %b expected 0", overflow); end
    lrck = 1'b0;
    tick(); tick(); tick();
    for (int k = 1; k < 4; k++) begin
      lrck_pop(re, im, e, u, a);
      checks++; if ({re, im} !== {24'(8'h11 + k), 24'(8'h21 + k)}) begin failures++; $display("FAIL pp_old%0d: got %h expected %h", k, {re, im}, {24'(8'h11 + k), 24'(8'h21 + k)}); end
    end
    lrck_pop(re, im, e, u, a);
    checks++; if ({re, im} !== {24'h30, 24'h31}) begin failures++; $display("FAIL pp_new: got %h expected %h", {re, im}, {24'h30, 24'h31}); end
  endtask

  task automatic test_reset_mid();
    logic [23:0] re, im;
    logic e, u, a;
    for (int k = 5; k < 8; k++) push(32'(k) << 8, 32'(k + 1) << 8);
    checks++; if (fifo_level !== 3'd3) begin failures++; $display("FAIL rm_level_pre: got %0d expected 3", fifo_level); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({rx_real, rx_imag} !== 48'h0) begin failures++; $display("FAIL rm_rx: got %h expected 0", {rx_real, rx_imag}); end
    checks++; if ({out_update, overflow, underflow} !== 3'b000) begin failures++; $display("FAIL rm_bits: got %b expected 000", {out_update, overflow, underflow}); end
    checks++; if (fifo_level !== 3'd0) begin failures++; $display("FAIL rm_level: got %0d expected 0", fifo_level); end
    push(32'h0000_0700, 32'h0000_0800);
    lrck_pop(re, im, e, u, a);
    checks++; if ({re, im} !== 48'h0) begin failures++; $display("FAIL rm_fill_rx: got %h expected 0", {re, im}); end
    checks++; if (fifo_level !== 3'd1) begin failures++; $display("FAIL rm_fill_level: got %0d expected 1", fifo_level); end
    push(32'h0000_0900, 32'h0000_0A00);
    lrck_pop(re, im, e, u, a);
    checks++; if ({re, im} !== {24'h7, 24'h8}) begin failures++; $display("FAIL rm_first_after: got %h expected %h", {re, im}, {24'h7, 24'h8}); end
  endtask

`ifdef IQ_SWAP_EN
  task automatic test_iq_swap();
    logic [23:0] re, im;
    logic e, u, a;
    push(32'h0001_0000, 32'h0002_0000);
    lrck_pop(re, im, e, u, a);
    checks++; if ({re, im} !== {24'h9, 24'hA}) begin failures++; $display("FAIL swap_off: got %h expected %h", {re, im}, {24'h9, 24'hA}); end
    iq_swap = 1'b1;
    lrck_pop(re, im, e, u, a);
    iq_swap = 1'b0;
    checks++; if ({re, im} !== {24'h200, 24'h100}) begin failures++; $display("FAIL swap_on: got %h expected %h", {re, im}, {24'h200, 24'h100}); end
  endtask
`endif

  initial begin
    reset = 1'b1; in_valid = 1'b0; lrck = 1'b0; clr_flags = 1'b0;
    in_real = '0; in_imag = '0;
`ifdef IQ_SWAP_EN
    iq_swap = 1'b0;
`endif
    test_reset();
    test_round_sat();
    test_fill_run();
    test_overflow();
    test_flags();
    test_push_pop_full();
    test_reset_mid();
`ifdef IQ_SWAP_EN
    test_iq_swap();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
